nim_player: RTL and testbench
=============================

Name: nim_player

Overview:
- Automated Nim opponent that plays the environment (player 0) side against the nim game engine.
- Receives the current pile contents as a serial stream of NCOL beats and computes a move with Sprague-Grundy (nim-sum) analysis, one pile per clock.
- Offers the move as (col, num) on a valid/ready handshake that feeds the engine's col/num inputs.
- From a winning position it plays perfectly. From a losing position it removes one counter from the first non-empty pile.

Parameters:
- LOGCOL, 2, log2 of the pile count.
- LOGCNT, 4, bits per pile counter.
- NCOL, 1<<LOGCOL, number of piles.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- pile_valid, input, 1, pile_data carries the current pile.
- pile_ready, output, 1, block accepts a pile beat.
- pile_data, input, LOGCNT, counter count of the pile at load_idx.
- move_valid, output, 1, col/num hold an offered move.
- move_ready, input, 1, consumer accepts the move.
- col, output, LOGCOL, pile to take from.
- num, output, LOGCNT, counters to remove (at least 1).
- winning, output, 1, nim-sum of the last loaded set is nonzero.
- no_move, output, 1, one-cycle pulse meaning all piles are empty and no move is possible.

Behaviour:
- One clock domain. Reset is asynchronous and active-high; the clock port is named clock and the reset port is named reset.
- Reset state: FSM in LOAD, load_idx=0, value=0, search_idx=0.
- Reset values: pile_ready=1, move_valid=0, col=0, num=0, winning=0, no_move=0.
- States: LOAD, SEARCH, OFFER, NOMOVE.
- LOAD:
  - pile_ready=1.
  - On each pile_valid&&pile_ready beat: pile[load_idx]<=pile_data, value<=value^pile_data, load_idx++.
  - On the beat with load_idx==NCOL-1: load_idx<=0, search_idx<=0, go to SEARCH.
  - Gaps in pile_valid are allowed; there is no timeout.
- SEARCH:
  - pile_ready=0. Examines pile[search_idx] once per cycle.
  - winning<=(value!=0) on the first SEARCH cycle.
  - If value!=0: temp=value^pile[i]. If temp<pile[i], then col<=i, num<=pile[i]-temp, go to OFFER.
  - If value==0: if pile[i]>0, then col<=i, num<=1, go to OFFER.
  - Otherwise search_idx++. If no match at i==NCOL-1, go to NOMOVE.
  - A nonzero value always matches some pile, so NOMOVE is reached only when every pile is 0.
- Latency: last pile beat accepted at edge t; pile k is examined in cycle t+1+k; move_valid rises in cycle t+2+k.
- OFFER:
  - move_valid=1; col and num are held stable until move_ready.
  - On move_valid&&move_ready: move_valid<=0, value<=0, go to LOAD for the next position.
  - move_ready asserted early (before OFFER) has no effect.
- NOMOVE: no_move=1 for exactly one cycle, then value<=0, go to LOAD. move_valid is never asserted.
- Width rules:
  - value and temp are LOGCNT bits. The subtraction pile-temp cannot underflow because temp<pile is checked first.
  - col is the LOGCOL-bit index truncation of search_idx; search_idx is LOGCOL+1 bits to detect the end.
- Reset mid-operation, in any state: return immediately to LOAD. Partial pile sets and offered moves are discarded. move_valid and no_move drop asynchronously. The next NCOL beats form a fresh set.
- winning holds its value until the next set enters SEARCH.

Decomposition:
- Shared package nim_pkg: LOGCOL, LOGCNT and NCOL defaults; the state enum {LOAD, SEARCH, OFFER, NOMOVE}; a move struct {col, num}.
- The game engine also uses nim_pkg.
- One sub-module, nim_pile_store:
  - NCOL x LOGCNT register file.
  - Write port indexed by load_idx; read port indexed by search_idx.
  - Running XOR accumulator with a clear input.
- The FSM and move arithmetic stay in nim_player.

Test Plan:
- Piles 3,4,5,0 (value 2) with move_ready=1 -> pile0: 3^2=1<3 -> col=0, num=2, move_valid in cycle t+2, winning=1.
- Piles 1,2,3,0 (value 0) -> col=0, num=1, winning=0.
- Piles 0,0,0,0 -> no_move high exactly in cycle t+5, move_valid never high, pile_ready=1 from t+6.
- Piles 0,0,0,9 -> col=3, num=9, move_valid first high in cycle t+5.
- Backpressure: move_ready low for 5 cycles, then high for 1 -> col/num stable throughout, move_valid drops after the handshake, pile_ready=1 the next cycle.
- Reset after 2 of 4 beats of 7,7,7,7, then beats 3,4,5,0 -> result col=0, num=2; the partial set leaves no trace.

Source files
------------

// File: rtl/nim_pkg.sv
// Shared Nim definitions used by the player and the game engine.
// Holds default geometry, the player FSM state encoding and the move payload.
package nim_pkg;

    localparam int unsigned NIM_LOGCOL = 2;
    localparam int unsigned NIM_LOGCNT = 4;
    localparam int unsigned NIM_NCOL   = 1 << NIM_LOGCOL;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        OFFER  = 2'd2,
        NOMOVE = 2'd3
    } state_t;

    typedef struct packed {
        logic [NIM_LOGCOL-1:0] col;
        logic [NIM_LOGCNT-1:0] num;
    } move_t;

endpackage

// File: rtl/nim_pile_store.sv
// Pile register file with a running XOR (nim-sum) accumulator.
// Ports: clock/reset; write port (wr_en, wr_idx, wr_data) also folds wr_data
// into value; read port (rd_idx -> rd_data, combinational); clear zeroes value.
module nim_pile_store import nim_pkg::*; #(
    parameter int unsigned LOGCOL = NIM_LOGCOL,
    parameter int unsigned LOGCNT = NIM_LOGCNT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [LOGCOL-1:0] wr_idx,
    input  logic [LOGCNT-1:0] wr_data,
    input  logic [LOGCOL-1:0] rd_idx,
    output logic [LOGCNT-1:0] rd_data,
    input  logic              clear,
    output logic [LOGCNT-1:0] value
);

    localparam int unsigned NCOL = 1 << LOGCOL;

    logic [LOGCNT-1:0] piles [NCOL];

    // Pile storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NCOL); i++) begin
                piles[i] <= '0;
            end
        end else if (wr_en) begin
            piles[wr_idx] <= wr_data;
        end
    end

    // Nim-sum accumulator; clear wins over a simultaneous write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (wr_en) begin
            value <= value ^ wr_data;
        end
    end

    assign rd_data = piles[rd_idx];

endmodule

// File: rtl/nim_player.sv
// Automated Nim opponent: loads NCOL pile beats, then scans piles one per
// clock for a nim-sum-zeroing move (or a single-counter fallback) and offers it.
// Ports: clock, reset (async, active-high); pile_valid/pile_ready/pile_data
// input stream; move_valid/move_ready with col/num move payload; winning
// (nim-sum of last set nonzero); no_move (one-cycle pulse, all piles empty).
module nim_player #(
    parameter int unsigned LOGCOL = nim_pkg::NIM_LOGCOL,
    parameter int unsigned LOGCNT = nim_pkg::NIM_LOGCNT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pile_valid,
    output logic              pile_ready,
    input  logic [LOGCNT-1:0] pile_data,
    output logic              move_valid,
    input  logic              move_ready,
    output logic [LOGCOL-1:0] col,
    output logic [LOGCNT-1:0] num,
    output logic              winning,
    output logic              no_move
);
    import nim_pkg::*;

    localparam int unsigned NCOL = 1 << LOGCOL;
    localparam logic [LOGCOL-1:0] LAST_LOAD   = LOGCOL'(NCOL - 1);
    localparam logic [LOGCOL:0]   LAST_SEARCH = (LOGCOL+1)'(NCOL - 1);

    state_t            state_q, state_d;
    logic [LOGCOL-1:0] load_q, load_d;
    logic [LOGCOL:0]   search_q, search_d;
    logic [LOGCOL-1:0] col_d;
    logic [LOGCNT-1:0] num_d;
    logic              pile_ready_d, move_valid_d, winning_d, no_move_d;

    logic              wr_en, clear;
    logic [LOGCNT-1:0] rd_data, value, temp, take;
    logic              match;

    nim_pile_store #(
        .LOGCOL (LOGCOL),
        .LOGCNT (LOGCNT)
    ) u_store (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (load_q),
        .wr_data (pile_data),
        .rd_idx  (search_q[LOGCOL-1:0]),
        .rd_data (rd_data),
        .clear   (clear),
        .value   (value)
    );

    // Move arithmetic for the pile under examination; temp<pile guards the subtraction
    always_comb begin
        temp = value ^ rd_data;
        if (value != '0) begin
            match = (temp < rd_data);
            take  = rd_data - temp;
        end else begin
            match = (rd_data != '0);
            take  = LOGCNT'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= LOAD;
            load_q     <= '0;
            search_q   <= '0;
            pile_ready <= 1'b1;
            move_valid <= 1'b0;
            col        <= '0;
            num        <= '0;
            winning    <= 1'b0;
            no_move    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            search_q   <= search_d;
            pile_ready <= pile_ready_d;
            move_valid <= move_valid_d;
            col        <= col_d;
            num        <= num_d;
            winning    <= winning_d;
            no_move    <= no_move_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        search_d     = search_q;
        col_d        = col;
        num_d        = num;
        winning_d    = winning;
        move_valid_d = 1'b0;
        no_move_d    = 1'b0;
        wr_en        = 1'b0;
        clear        = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (pile_valid && pile_ready) begin
                    wr_en = 1'b1;
                    if (load_q == LAST_LOAD) begin
                        load_d   = '0;
                        search_d = '0;
                        state_d  = SEARCH;
                    end else begin
                        load_d = load_q + LOGCOL'(1);
                    end
                end
            end
            SEARCH: begin
                if (search_q == '0) begin
                    winning_d = (value != '0);
                end
                if (match) begin
                    col_d        = search_q[LOGCOL-1:0];
                    num_d        = take;
                    move_valid_d = 1'b1;
                    state_d      = OFFER;
                end else if (search_q == LAST_SEARCH) begin
                    no_move_d = 1'b1;
                    state_d   = NOMOVE;
                end else begin
                    search_d = search_q + (LOGCOL+1)'(1);
                end
            end
            OFFER: begin
                move_valid_d = 1'b1;
                if (move_ready) begin
                    move_valid_d = 1'b0;
                    clear        = 1'b1;
                    state_d      = LOAD;
                end
            end
            NOMOVE: begin
                clear   = 1'b1;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase

        pile_ready_d = (state_d == LOAD);
    end

endmodule

// File: tb/tb_nim_player.sv
// Randomized self-checking bench for nim_player against a brute-force Nim model.
module tb_nim_player;

    localparam int unsigned LOGCOL = 2;
    localparam int unsigned LOGCNT = 4;
    localparam int NCOL = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              pile_valid = 1'b0;
    logic [LOGCNT-1:0] pile_data = '0;
    logic              move_ready = 1'b0;
    logic              pile_ready, move_valid, winning, no_move;
    logic [LOGCOL-1:0] col;
    logic [LOGCNT-1:0] num;

    nim_player #(.LOGCOL(LOGCOL), .LOGCNT(LOGCNT)) dut (
        .clock      (clock),
        .reset      (reset),
        .pile_valid (pile_valid),
        .pile_ready (pile_ready),
        .pile_data  (pile_data),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .col        (col),
        .num        (num),
        .winning    (winning),
        .no_move    (no_move)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Expected per-cycle outputs, maintained by the driver from the model
    logic e_pr = 1'b1, e_mv = 1'b0, e_nm = 1'b0, e_win = 1'b0;
    int   e_col = 0, e_num = 0;
    logic e_cn_zero = 1'b1;

    task automatic cmp(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Brute force: a winning move is the first pile with some removal leaving nim-sum 0
    function automatic void model(input int p[4], output int v, output int k, output int n);
        v = 0;
        k = -1;
        n = 0;
        for (int i = 0; i < NCOL; i++) v = v ^ p[i];
        for (int i = 0; i < NCOL && k < 0; i++) begin
            if (v != 0) begin
                for (int m = 1; m <= p[i] && k < 0; m++) begin
                    int s = 0;
                    for (int j = 0; j < NCOL; j++) s = s ^ ((j == i) ? p[j] - m : p[j]);
                    if (s == 0) begin
                        k = i;
                        n = m;
                    end
                end
            end else if (p[i] > 0) begin
                k = i;
                n = 1;
            end
        end
    endfunction

    // Per-cycle output check
    always @(negedge clock) begin
        cmp("pile_ready", int'(pile_ready), int'(e_pr));
        cmp("move_valid", int'(move_valid), int'(e_mv));
        cmp("no_move", int'(no_move), int'(e_nm));
        cmp("winning", int'(winning), int'(e_win));
        if (e_mv || e_cn_zero) begin
            cmp("col", int'(col), e_mv ? e_col : 0);
            cmp("num", int'(num), e_mv ? e_num : 0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        e_pr = 1'b1; e_mv = 1'b0; e_nm = 1'b0; e_win = 1'b0; e_cn_zero = 1'b1;
        #1;
        cmp("async_move_valid_drop", int'(move_valid), 0);
        cmp("async_no_move_drop", int'(no_move), 0);
        step();
        step();
        reset = 1'b0;
        e_cn_zero = 1'b0;
    endtask

    task automatic beat(input int d);
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            pile_data  = LOGCNT'($urandom);
            move_ready = 1'($urandom);
            step();
        end
        pile_valid = 1'b1;
        pile_data  = LOGCNT'(d);
        step();
        pile_valid = 1'b0;
        pile_data  = LOGCNT'($urandom);
        move_ready = 1'($urandom);
    endtask

    // ready_delay < 0: reset is applied while the move is on offer
    task automatic run_set(input int p[4], input int ready_delay);
        int v, k, n;
        model(p, v, k, n);
        for (int i = 0; i < NCOL; i++) beat(p[i]);
        e_pr = 1'b0;
        if (k < 0) begin
            for (int j = 0; j < NCOL; j++) begin
                step();
                if (j == 0) e_win = (v != 0);
            end
            e_nm = 1'b1;
            step();
            e_nm = 1'b0;
            e_pr = 1'b1;
        end else begin
            for (int j = 0; j <= k; j++) begin
                step();
                if (j == 0) e_win = (v != 0);
                move_ready = 1'($urandom);
            end
            e_mv  = 1'b1;
            e_col = k;
            e_num = n;
            move_ready = 1'b0;
            if (ready_delay < 0) begin
                step();
                do_reset();
            end else begin
                for (int d = 0; d < ready_delay; d++) step();
                move_ready = 1'b1;
                step();
                move_ready = 1'b0;
                e_mv = 1'b0;
                e_pr = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p[4];
        int v, k, n;

        step(); step(); step();
        reset = 1'b0;
        e_cn_zero = 1'b0;

        // Hand-computed pins on the model
        p = '{3, 4, 5, 0}; model(p, v, k, n);
        cmp("pin_a_value", v, 2); cmp("pin_a_col", k, 0); cmp("pin_a_num", n, 2);
        p = '{1, 2, 3, 0}; model(p, v, k, n);
        cmp("pin_b_value", v, 0); cmp("pin_b_col", k, 0); cmp("pin_b_num", n, 1);
        p = '{0, 0, 0, 0}; model(p, v, k, n);
        cmp("pin_c_col", k, -1);
        p = '{0, 0, 0, 9}; model(p, v, k, n);
        cmp("pin_d_col", k, 3); cmp("pin_d_num", n, 9);
        p = '{7, 7, 7, 1}; model(p, v, k, n);
        cmp("pin_e_value", v, 6); cmp("pin_e_col", k, 0); cmp("pin_e_num", n, 6);

        // Directed scenarios
        p = '{3, 4, 5, 0}; run_set(p, 0);
        p = '{1, 2, 3, 0}; run_set(p, 0);
        p = '{0, 0, 0, 0}; run_set(p, 0);
        p = '{0, 0, 0, 9}; run_set(p, 0);
        p = '{3, 4, 5, 0}; run_set(p, 5);

        // Reset after a partial set of 7s, then a fresh set
        beat(7);
        beat(7);
        do_reset();
        p = '{3, 4, 5, 0}; run_set(p, 0);

        // Reset while a move is on offer
        p = '{0, 5, 0, 2}; run_set(p, -1);
        p = '{15, 15, 1, 0}; run_set(p, 2);

        // Randomized sets
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < NCOL; i++) begin
                p[i] = ($urandom_range(0, 3) == 0 || (t % 9) == 4) ? 0 : int'($urandom_range(1, 15));
            end
            run_set(p, ((t % 13) == 7) ? -1 : int'($urandom_range(0, 3)));
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
